// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
// Optional feature macro used by this slice: MEM_ARB_ROUND_ROBIN_EN.
package mem_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Word accesses only: any set low address bit is a misaligned request.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection for the two requesters.
// MEM_ARB_ROUND_ROBIN_EN defined: alternate on contention using the
// last-granted pointer. Undefined: port 1 (data) has fixed priority and
// no pointer input exists.
module mem_arb_pick
    import mem_ctrl_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic       last1,
`endif
    output logic [1:0] grant
);

    // One-hot grant; never both bits set.
    always_comb begin
        grant = 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (valid0 && valid1) begin
            grant = last1 ? 2'b01 : 2'b10;
        end else if (valid1) begin
            grant = 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else begin
            grant = 2'b00;
        end
`else
        if (valid1) begin
            grant = 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else begin
            grant = 2'b00;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port word memory.
// One request at a time: IDLE -> ISSUE -> (WAIT) -> RESP, or IDLE -> RESP
// for misaligned requests. Macro: MEM_ARB_ROUND_ROBIN_EN selects
// round-robin arbitration instead of fixed port-1 priority.
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int RD_LAT = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    input  logic              req0_write,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              resp0_err,
    output logic              resp1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    mem_req_t          req_r;
    mem_req_t          sel_req_s;
    logic              port_r;
    logic              sel_port_s;
    logic [1:0]        cnt_r;
    logic [1:0]        grant_s;
    logic              hs_s;
    logic              mis_s;
    logic              mem_read_r;
    logic              mem_write_r;
    logic              resp_port_s;
    logic              resp_err_s;
    logic [DATA_W-1:0] resp_rdata_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last1_r;
`endif

    mem_arb_pick u_pick (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last1  (last1_r),
`endif
        .grant  (grant_s)
    );

    // The request latch doubles as the memory address/data drivers.
    assign mem_addr  = req_r.addr;
    assign mem_wdata = req_r.wdata;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;

    // Ready only in IDLE, only for the granted port, never during reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (reset_n && (state_r == IDLE)) begin
            req0_ready = grant_s[0];
            req1_ready = grant_s[1];
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Handshake detection and selection of the granted request fields.
    always_comb begin
        hs_s       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        sel_port_s = grant_s[1];
        if (grant_s[1]) begin
            sel_req_s = '{write: req1_write, addr: req1_addr, wdata: req1_wdata};
        end else begin
            sel_req_s = '{write: req0_write, addr: req0_addr, wdata: req0_wdata};
        end
        mis_s = is_misaligned(sel_req_s.addr);
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (hs_s) begin
                    state_nxt_s = mis_s ? RESP : ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (req_r.write || (RD_LAT_C == 2'd0)) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r <= 2'd1) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Response contents to register when RESP is entered; a misaligned
    // request goes straight from IDLE, so only that path carries err.
    always_comb begin
        resp_port_s  = port_r;
        resp_err_s   = 1'b0;
        resp_rdata_s = {DATA_W{1'b0}};
        if (state_r == IDLE) begin
            resp_port_s  = sel_port_s;
            resp_err_s   = mis_s;
            resp_rdata_s = {DATA_W{1'b0}};
        end else begin
            resp_port_s  = port_r;
            resp_err_s   = 1'b0;
            resp_rdata_s = req_r.write ? {DATA_W{1'b0}} : mem_rdata;
        end
    end

    // FSM state, request latch, wait counter, strobes and response pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            req_r       <= '{write: 1'b0, addr: {ADDR_W{1'b0}}, wdata: {DATA_W{1'b0}}};
            port_r      <= 1'b0;
            cnt_r       <= 2'd0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_rdata <= {DATA_W{1'b0}};
            resp1_rdata <= {DATA_W{1'b0}};
            resp0_err   <= 1'b0;
            resp1_err   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last1_r     <= 1'b1;
`endif
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (hs_s) begin
                        req_r       <= sel_req_s;
                        port_r      <= sel_port_s;
                        cnt_r       <= RD_LAT_C;
                        mem_write_r <= !mis_s && sel_req_s.write;
                        mem_read_r  <= !mis_s && !sel_req_s.write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last1_r     <= sel_port_s;
`endif
                    end else begin
                        mem_write_r <= 1'b0;
                        mem_read_r  <= 1'b0;
                    end
                end
                ISSUE: begin
                    mem_write_r <= 1'b0;
                    mem_read_r  <= !req_r.write && (RD_LAT_C != 2'd0);
                end
                WAIT: begin
                    cnt_r       <= cnt_r - 2'd1;
                    mem_write_r <= 1'b0;
                    mem_read_r  <= (cnt_r > 2'd1);
                end
                RESP: begin
                    mem_write_r <= 1'b0;
                    mem_read_r  <= 1'b0;
                end
                default: begin
                    mem_write_r <= 1'b0;
                    mem_read_r  <= 1'b0;
                end
            endcase
            if (state_nxt_s == RESP) begin
                resp0_valid <= !resp_port_s;
                resp1_valid <= resp_port_s;
                resp0_rdata <= resp_port_s ? {DATA_W{1'b0}} : resp_rdata_s;
                resp1_rdata <= resp_port_s ? resp_rdata_s : {DATA_W{1'b0}};
                resp0_err   <= !resp_port_s && resp_err_s;
                resp1_err   <= resp_port_s && resp_err_s;
            end else begin
                resp0_valid <= 1'b0;
                resp1_valid <= 1'b0;
                resp0_rdata <= {DATA_W{1'b0}};
                resp1_rdata <= {DATA_W{1'b0}};
                resp0_err   <= 1'b0;
                resp1_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven single requests with a
// response scoreboard, plus hand sequences for reset, contention and a
// second instance built with RD_LAT = 2.
module tb_mem_arbiter;

    logic        clock;
    logic        reset_n;

    // Instance with RD_LAT = 0
    logic        req0_valid, req1_valid, req0_write, req1_write;
    logic [7:0]  req0_addr, req1_addr;
    logic [31:0] req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [31:0] resp0_rdata, resp1_rdata;
    logic        resp0_err, resp1_err;
    logic [7:0]  mem_addr;
    logic        mem_read, mem_write;
    logic [31:0] mem_wdata, mem_rdata;

    // Instance with RD_LAT = 2
    logic        b_req0_valid, b_req1_valid, b_req0_write, b_req1_write;
    logic [7:0]  b_req0_addr, b_req1_addr;
    logic [31:0] b_req0_wdata, b_req1_wdata;
    logic        b_req0_ready, b_req1_ready, b_resp0_valid, b_resp1_valid;
    logic [31:0] b_resp0_rdata, b_resp1_rdata;
    logic        b_resp0_err, b_resp1_err;
    logic [7:0]  b_mem_addr;
    logic        b_mem_read, b_mem_write;
    logic [31:0] b_mem_wdata, b_mem_rdata;

    logic [31:0] mem0 [0:63];
    logic [31:0] mem2 [0:63];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_e;

    typedef struct {
        logic        port;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;
    vec_t vecs[13];

    mem_arbiter #(.RD_LAT(0)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_write(req0_write), .req1_write(req1_write),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_rdata(resp0_rdata), .resp1_rdata(resp1_rdata),
        .resp0_err(resp0_err), .resp1_err(resp1_err),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.RD_LAT(2)) dut_lat2 (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(b_req0_valid), .req1_valid(b_req1_valid),
        .req0_write(b_req0_write), .req1_write(b_req1_write),
        .req0_addr(b_req0_addr), .req1_addr(b_req1_addr),
        .req0_wdata(b_req0_wdata), .req1_wdata(b_req1_wdata),
        .req0_ready(b_req0_ready), .req1_ready(b_req1_ready),
        .resp0_valid(b_resp0_valid), .resp1_valid(b_resp1_valid),
        .resp0_rdata(b_resp0_rdata), .resp1_rdata(b_resp1_rdata),
        .resp0_err(b_resp0_err), .resp1_err(b_resp1_err),
        .mem_addr(b_mem_addr), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memories: asynchronous read, write committed at the clock edge.
    assign mem_rdata   = mem0[mem_addr[7:2]];
    assign b_mem_rdata = mem2[b_mem_addr[7:2]];

    always @(posedge clock) begin
        if (mem_write) mem0[mem_addr[7:2]] <= mem_wdata;
        if (b_mem_write) mem2[b_mem_addr[7:2]] <= b_mem_wdata;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard/monitor for the RD_LAT = 0 instance.
    always @(negedge clock) begin
        if (req0_ready && req1_ready) begin
            checks++; errors++;
            $display("FAIL ready_both actual=11 expected=one-hot");
        end
        if (mem_read && mem_write) begin
            checks++; errors++;
            $display("FAIL strobes_both actual=11 expected=not both");
        end
        if (resp0_valid || resp1_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected actual=v0:%0b v1:%0b expected=no response", resp0_valid, resp1_valid);
            end else begin
                sb_e = sb_q.pop_front();
                if ((resp1_valid !== sb_e.port) || (resp0_valid !== !sb_e.port) ||
                    ((sb_e.port ? resp1_rdata : resp0_rdata) !== sb_e.rdata) ||
                    ((sb_e.port ? resp1_err : resp0_err) !== sb_e.err)) begin
                    errors++;
                    $display("FAIL resp_data actual=v0:%0b v1:%0b d0:%08h d1:%08h e0:%0b e1:%0b expected=port%0d data:%08h err:%0b",
                             resp0_valid, resp1_valid, resp0_rdata, resp1_rdata, resp0_err, resp1_err,
                             sb_e.port, sb_e.rdata, sb_e.err);
                end
            end
        end
    end

    task automatic drive_port(input logic port, input logic v, input logic wr,
                              input logic [7:0] addr, input logic [31:0] wdata);
        if (port) begin
            req1_valid = v; req1_write = wr; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = v; req0_write = wr; req0_addr = addr; req0_wdata = wdata;
        end
    endtask

    // One request on the RD_LAT = 0 instance; reports latency and strobe cycles.
    task automatic do_req(input logic port, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, output int lat, output int nrd, output int nwr);
        bit got;
        lat = -1; nrd = 0; nwr = 0;
        drive_port(port, 1'b1, wr, addr, wdata);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (port ? req1_ready : req0_ready) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ready_timeout port=%0d addr=%02h actual=no ready expected=ready", port, addr);
            drive_port(port, 1'b0, 1'b0, 8'h00, 32'h0);
        end else begin
            sb_q.push_back('{port, exp_rdata, exp_err});
            @(posedge clock);
            #1;
            drive_port(port, 1'b0, 1'b0, 8'h00, 32'h0);
            got = 1'b0;
            for (int i = 1; i <= 20 && !got; i++) begin
                @(negedge clock);
                nrd += int'(mem_read);
                nwr += int'(mem_write);
                if (port ? resp1_valid : resp0_valid) begin
                    got = 1'b1;
                    lat = i;
                end
            end
        end
    endtask

    initial begin
        int lat, nrd, nwr, n, cnt;
        int grants[4];
        int exp_grants[4];
        bit got;
        logic [31:0] rd;
        logic er;

        for (int i = 0; i < 64; i++) begin
            mem0[i] = 32'h0;
            mem2[i] = 32'h0;
        end
        mem2[2] = 32'h0000_0005;

        b_req0_valid = 1'b0; b_req0_write = 1'b0; b_req0_addr = 8'h00; b_req0_wdata = 32'h0;
        b_req1_valid = 1'b0; b_req1_write = 1'b0; b_req1_addr = 8'h00; b_req1_wdata = 32'h0;

        // Reset with both requesters asserting: ready must stay low.
        reset_n = 1'b0;
        drive_port(1'b0, 1'b1, 1'b0, 8'h04, 32'h0);
        drive_port(1'b1, 1'b1, 1'b0, 8'h08, 32'h0);
        repeat (2) @(negedge clock);
        check("reset_ctrl", {24'h0, req0_ready, req1_ready, resp0_valid, resp1_valid,
                             resp0_err, resp1_err, mem_read, mem_write}, 32'h0);
        check("reset_addr", {24'h0, mem_addr}, 32'h0);
        check("reset_wdata", mem_wdata, 32'h0);
        check("reset_rdata", resp0_rdata | resp1_rdata, 32'h0);
        @(posedge clock);
        #1;
        drive_port(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive_port(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        //         port  wr    addr   wdata  exp_rd  err  lat rd wr
        vecs[0]  = '{1'b0, 1'b1, 8'h04, 32'h2, 32'h0, 1'b0, 2, 0, 1};
        vecs[1]  = '{1'b0, 1'b0, 8'h04, 32'h0, 32'h2, 1'b0, 2, 1, 0};
        vecs[2]  = '{1'b1, 1'b1, 8'h08, 32'h5, 32'h0, 1'b0, 2, 0, 1};
        vecs[3]  = '{1'b1, 1'b1, 8'h0C, 32'h9, 32'h0, 1'b0, 2, 0, 1};
        vecs[4]  = '{1'b1, 1'b1, 8'h18, 32'h7, 32'h0, 1'b0, 2, 0, 1};
        vecs[5]  = '{1'b1, 1'b1, 8'h1C, 32'hA, 32'h0, 1'b0, 2, 0, 1};
        vecs[6]  = '{1'b1, 1'b0, 8'h18, 32'h0, 32'h7, 1'b0, 2, 1, 0};
        vecs[7]  = '{1'b0, 1'b0, 8'h04, 32'h0, 32'h2, 1'b0, 2, 1, 0};
        vecs[8]  = '{1'b1, 1'b0, 8'h1C, 32'h0, 32'hA, 1'b0, 2, 1, 0};
        vecs[9]  = '{1'b0, 1'b0, 8'h08, 32'h0, 32'h5, 1'b0, 2, 1, 0};
        vecs[10] = '{1'b1, 1'b0, 8'h0C, 32'h0, 32'h9, 1'b0, 2, 1, 0};
        vecs[11] = '{1'b0, 1'b0, 8'h06, 32'h0, 32'h0, 1'b1, 1, 0, 0};
        vecs[12] = '{1'b1, 1'b1, 8'h0D, 32'h3, 32'h0, 1'b1, 1, 0, 0};

        for (int i = 0; i < 13; i++) begin
            do_req(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, lat, nrd, nwr);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_read_cycles", i), 32'(nrd), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_write_cycles", i), 32'(nwr), 32'(vecs[i].exp_wr));
            @(posedge clock);
            #1;
        end
        check("misaligned_write_no_commit", mem0[3], 32'h9);

        // Reset while ISSUE is active: no response, strobes low next cycle.
        drive_port(1'b0, 1'b1, 1'b1, 8'h20, 32'h0000_DEAD);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (req0_ready) got = 1'b1;
        end
        check("midreset_ready", {31'h0, got}, 32'h1);
        @(posedge clock);
        #1;
        drive_port(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clock);
        check("midreset_in_issue", {31'h0, mem_write}, 32'h1);
        reset_n = 1'b0;
        @(negedge clock);
        check("midreset_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clock);
            cnt += int'(resp0_valid) + int'(resp1_valid);
        end
        check("midreset_no_resp", 32'(cnt), 32'h0);

        // Contention: both ports valid every cycle, four grants recorded.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_grants = '{0, 1, 0, 1};
`else
        exp_grants = '{1, 1, 1, 1};
`endif
        @(posedge clock);
        #1;
        drive_port(1'b0, 1'b1, 1'b0, 8'h04, 32'h0);
        drive_port(1'b1, 1'b1, 1'b0, 8'h08, 32'h0);
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clock);
            if (req0_ready) begin
                grants[n] = 0;
                sb_q.push_back('{1'b0, 32'h2, 1'b0});
                n++;
            end else if (req1_ready) begin
                grants[n] = 1;
                sb_q.push_back('{1'b1, 32'h5, 1'b0});
                n++;
            end
        end
        @(posedge clock);
        #1;
        drive_port(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive_port(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        check("contention_grant_count", 32'(n), 32'h4);
        for (int g = 0; g < 4; g++) begin
            if (g < n) check($sformatf("contention_grant%0d", g), 32'(grants[g]), 32'(exp_grants[g]));
        end
        repeat (6) @(negedge clock);

        // RD_LAT = 2 instance: port 1 reads 0x08.
        @(posedge clock);
        #1;
        b_req1_valid = 1'b1; b_req1_write = 1'b0; b_req1_addr = 8'h08;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (b_req1_ready) got = 1'b1;
        end
        check("lat2_ready", {31'h0, got}, 32'h1);
        @(posedge clock);
        #1;
        b_req1_valid = 1'b0;
        got = 1'b0; lat = -1; nrd = 0; rd = 32'h0; er = 1'b1;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clock);
            nrd += int'(b_mem_read);
            if (b_resp0_valid) begin
                checks++; errors++;
                $display("FAIL lat2_wrong_port actual=resp0 expected=resp1");
            end
            if (b_resp1_valid) begin
                got = 1'b1; lat = i; rd = b_resp1_rdata; er = b_resp1_err;
            end
        end
        check("lat2_latency", 32'(lat), 32'h4);
        check("lat2_read_cycles", 32'(nrd), 32'h3);
        check("lat2_rdata", rd, 32'h5);
        check("lat2_err", {31'h0, er}, 32'h0);

        repeat (4) @(negedge clock);
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-port 256-byte word memory (`Memory`: `Address[7:0]`, `MemRead`, `MemWrite`, `writeData[31:0]`, `ReadData[31:0]`). Port 0 serves instruction fetch and port 1 serves load/store. The block accepts one request at a time over a valid/ready handshake and drives exactly one memory strobe cycle per request. It returns a one-cycle response pulse that carries the read data. It sits between the datapath requesters and the `Memory` instance.

## Interface
- `RD_LAT`, default 0: number of cycles after the strobe cycle before `mem_rdata` is sampled. Legal range 0..3.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_write`, `req1_write`  in  1  1 = write, 0 = read.
- `req0_addr`, `req1_addr`  in  8  byte address.
- `req0_wdata`, `req1_wdata`  in  32  write data.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `resp0_valid`, `resp1_valid`  out  1  one-cycle completion pulse.
- `resp0_rdata`, `resp1_rdata`  out  32  read data, valid with the matching `respN_valid`.
- `resp0_err`, `resp1_err`  out  1  misaligned access, valid with the matching `respN_valid`.
- `mem_addr`  out  8  to `Address`.
- `mem_read`  out  1  to `MemRead`.
- `mem_write`  out  1  to `MemWrite`.
- `mem_wdata`  out  32  to `writeData`.
- `mem_rdata`  in  32  from `ReadData`.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP. All transitions occur on the rising edge of `clock`.
- **IDLE:**
  - `reqN_ready` is combinational: it is high only for the single port chosen by the arbiter. Both ready signals are never high together.
  - On a handshake (`reqN_valid && reqN_ready`), latch port, write, addr and wdata.
  - If `addr[1:0] != 0`, go to RESP with err = 1. No memory strobe is issued.
  - Otherwise go to ISSUE.
- **ISSUE (exactly 1 cycle):**
  - `mem_addr` and `mem_wdata` come from the latch; `mem_write` = write and `mem_read` = !write.
  - Write: the memory commits at the end of the cycle; go to RESP.
  - Read with `RD_LAT` = 0: capture `mem_rdata` at the end of ISSUE; go to RESP.
  - Read with `RD_LAT` > 0: go to WAIT.
- **WAIT:** `mem_read` stays high and `mem_addr` is held. A down-counter starts at `RD_LAT`. Capture `mem_rdata` at the end of the cycle where the counter reaches 1, then go to RESP.
- **RESP (1 cycle):**
  - `respN_valid` = 1 for the latched port only.
  - `respN_rdata` = captured data for a read, 0 for a write or an error.
  - `respN_err` reflects the misaligned flag.
  - Next state is IDLE.
- **Strobes:** `mem_read` and `mem_write` are 0 in IDLE and RESP. They are never both high.
- **Simultaneous requests:** resolved by the arbitration policy in Configuration. The losing request stays pending with no ready, and the requester must hold it stable.
- **Requests outside IDLE:** ignored; ready stays 0.

## Timing
- **Reset:**
  - `reset_n` low at an edge sets state to IDLE.
  - Captured data, the err flag and the WAIT counter clear to 0. The round-robin pointer resets to "port 1 last granted".
  - All outputs are 0 during reset. `reqN_ready` is forced to 0 while `reset_n` is low.
- **Reset mid-operation:** the in-flight request is dropped. No response is produced. Strobes are low from the next cycle.
- **Latency:** with acceptance at edge T, ISSUE occupies T..T+1.
  - Write: response pulse in cycle T+1..T+2, back in IDLE at T+2.
  - Read: response `RD_LAT` cycles later than a write.
  - Misaligned: response in the cycle immediately after acceptance.
- **Throughput:** the next acceptance can occur in the first IDLE cycle after RESP. That gives a minimum of 3 cycles per aligned access.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - When both ports are valid in IDLE, grant the port not granted most recently.
  - The pointer updates on every handshake, including misaligned ones.
- `MEM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: port 1 (data) always wins over port 0.
  - No pointer register exists.

## Structure
- Package `mem_ctrl_pkg`:
  - `ADDR_W` = 8 and `DATA_W` = 32.
  - State enum `arb_state_t` {IDLE, ISSUE, WAIT, RESP}.
  - Request struct (write, addr, wdata).
- Sub-module `mem_arb_pick`: purely combinational grant logic.
  - Inputs: two valids and the pointer.
  - Output: one-hot grant.
  - Holds the `MEM_ARB_ROUND_ROBIN_EN` conditional.
- Top level: FSM, request latch, WAIT counter and response registers.

## Test plan
- **Reset values:** assert `reset_n` = 0 for 2 cycles → all outputs 0. Pull reset mid-ISSUE → no resp pulse, strobes low the next cycle.
- **Port 0 write/read-back (`RD_LAT` = 0):**
  - Write 0x00000002 to 0x04 → `mem_write` high for exactly 1 cycle, then `resp0_valid` with err = 0.
  - Read 0x04 → `resp0_rdata` = 0x00000002, 2 cycles after acceptance.
- **Interleaved writes and reads:**
  - Port 1 writes 0x5 @0x08, 0x9 @0x0C, 0x7 @0x18, 0xA @0x1C.
  - Reads of 0x18, 0x04, 0x1C, 0x08, 0x0C return 0x7, 0x2, 0xA, 0x5, 0x9.
- **Contention:** both ports valid every cycle.
  - With `MEM_ARB_ROUND_ROBIN_EN`: grants alternate 0,1,0,1.
  - Without it: port 1 is granted 4 times in a row.
  - In both builds the two ready signals are never high in the same cycle.
- **Misaligned request:** port 0 reads 0x06 → `resp0_err` = 1 and `resp0_rdata` = 0 one cycle after acceptance. No `mem_read` pulse.
- **`RD_LAT` = 2:** read 0x08 → `mem_read` high for 3 cycles and `resp1_rdata` = 0x5, 4 cycles after acceptance.
